// File: rtl/sram_rresp.sv
// sram_rresp: AXI-style read responder. Accepts one AR handshake, fetches
// BURST_LEN consecutive words from a synchronous single-port SRAM and returns
// them as an R burst, one beat every three cycles when the consumer is ready.
module sram_rresp #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic              i_aclk,
  input  logic              i_areset_n,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic              o_rlast,
  output logic              o_sram_en,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, VALID} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  beat;
  logic              err;

  // Address of the beat about to be fetched. The SRAM enable is registered on
  // entry to FETCH, so it is high exactly during FETCH and the read data lands
  // in time for WAIT to capture it.
  logic [ADDR_W-1:0] fetch_base;
  logic [CNT_W-1:0]  fetch_beat;
  logic [ADDR_W-1:0] waddr;
  logic              in_range;

  // Next word address and range check (wraps modulo 2^ADDR_W)
  always_comb begin
    fetch_base = base;
    fetch_beat = beat + CNT_W'(1);
    if (state == IDLE) begin
      fetch_base = i_araddr;
      fetch_beat = '0;
    end
    waddr    = fetch_base + ADDR_W'(fetch_beat);
    in_range = {1'b0, waddr} < DEPTH_L;
  end

  // Burst FSM with all outputs registered
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state       <= IDLE;
      o_arready   <= 1'b1;
      o_rvalid    <= 1'b0;
      o_rlast     <= 1'b0;
      o_rdata     <= '0;
      o_rresp     <= RESP_OKAY;
      o_sram_en   <= 1'b0;
      o_sram_addr <= '0;
      base        <= '0;
      beat        <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arvalid && o_arready) begin
            base      <= i_araddr;
            beat      <= '0;
            o_arready <= 1'b0;
            o_sram_en <= in_range;
            err       <= !in_range;
            if (in_range) o_sram_addr <= waddr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // Out-of-range beats never touched the SRAM; just drop the enable.
          o_sram_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          o_rdata  <= err ? '0 : i_sram_rdata;
          o_rresp  <= err ? RESP_SLVERR : RESP_OKAY;
          o_rlast  <= (beat == LAST_BEAT);
          o_rvalid <= 1'b1;
          state    <= VALID;
        end
        VALID: begin
          if (i_rready) begin
            o_rvalid <= 1'b0;
            if (o_rlast) begin
              o_rlast   <= 1'b0;
              o_arready <= 1'b1;
              state     <= IDLE;
            end else begin
              beat      <= fetch_beat;
              o_sram_en <= in_range;
              err       <= !in_range;
              if (in_range) o_sram_addr <= waddr;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rresp.sv
// Directed bench for sram_rresp. Two instances share the requester-side
// stimulus: dut_a has the full 256-word SRAM, dut_b only 200 valid words.
module tb_sram_rresp;

  logic        clk;
  logic        rst_n;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        rready;

  logic        a_arready, a_rvalid, a_rlast, a_sram_en;
  logic [31:0] a_rdata, a_srd;
  logic [1:0]  a_rresp;
  logic [7:0]  a_sram_addr;

  logic        b_arready, b_rvalid, b_rlast, b_sram_en;
  logic [31:0] b_rdata, b_srd;
  logic [1:0]  b_rresp;
  logic [7:0]  b_sram_addr;

  logic [31:0] mem [256];
  logic [7:0]  qa [$];
  logic [7:0]  qb [$];

  int checks = 0;
  int errors = 0;

  sram_rresp #(.ADDR_W(8), .DATA_W(32), .BURST_LEN(4), .MEM_DEPTH(256)) dut_a (
    .i_aclk(clk), .i_areset_n(rst_n), .i_araddr(araddr), .i_arvalid(arvalid),
    .o_arready(a_arready), .o_rdata(a_rdata), .o_rresp(a_rresp), .o_rvalid(a_rvalid),
    .i_rready(rready), .o_rlast(a_rlast), .o_sram_en(a_sram_en),
    .o_sram_addr(a_sram_addr), .i_sram_rdata(a_srd)
  );

  sram_rresp #(.ADDR_W(8), .DATA_W(32), .BURST_LEN(4), .MEM_DEPTH(200)) dut_b (
    .i_aclk(clk), .i_areset_n(rst_n), .i_araddr(araddr), .i_arvalid(arvalid),
    .o_arready(b_arready), .o_rdata(b_rdata), .o_rresp(b_rresp), .o_rvalid(b_rvalid),
    .i_rready(rready), .o_rlast(b_rlast), .o_sram_en(b_sram_en),
    .o_sram_addr(b_sram_addr), .i_sram_rdata(b_srd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 + k;

  // Synchronous SRAM models plus a log of every enabled address
  always @(posedge clk) begin
    if (a_sram_en) begin a_srd <= mem[a_sram_addr]; qa.push_back(a_sram_addr); end
    if (b_sram_en) begin b_srd <= mem[b_sram_addr]; qb.push_back(b_sram_addr); end
  end

  task automatic start_ar(input logic [7:0] a);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Waits (bounded) for rvalid on the chosen instance; caller does the checks
  task automatic get_beat(input bit sel, input int maxc, output logic [31:0] d,
                          output logic [1:0] r, output logic l, output logic v, output int w);
    w = 0;
    do begin
      @(negedge clk); w++;
      v = sel ? b_rvalid : a_rvalid;
    end while (!v && w < maxc);
    d = sel ? b_rdata : a_rdata;
    r = sel ? b_rresp : a_rresp;
    l = sel ? b_rlast : a_rlast;
  endtask

  task automatic test_reset;
    checks++;
    if ({a_arready, a_rvalid, a_rlast, a_sram_en} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 1000", {a_arready, a_rvalid, a_rlast, a_sram_en});
    end
    checks++;
    if ({a_rdata, a_rresp, a_sram_addr} !== 42'd0) begin
      errors++; $display("FAIL reset_data got %h/%b/%h exp 0", a_rdata, a_rresp, a_sram_addr);
    end
  endtask

  task automatic test_single;
    logic [31:0] d; logic [1:0] r; logic l, v; int w;
    qa.delete(); rready = 1'b1;
    checks++;
    if (a_arready !== 1'b1) begin errors++; $display("FAIL single_arready_idle got %b exp 1", a_arready); end
    start_ar(8'h01);
    checks++;
    if ({a_arready, a_sram_en, a_sram_addr} !== {1'b0, 1'b1, 8'h01}) begin
      errors++; $display("FAIL single_fetch0 got %b/%b/%h exp 0/1/01", a_arready, a_sram_en, a_sram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      get_beat(1'b0, 10, d, r, l, v, w);
      checks++;
      if (v !== 1'b1 || w != (i == 0 ? 2 : 3)) begin
        errors++; $display("FAIL single_lat%0d valid=%b waited=%0d exp 1/%0d", i, v, w, i == 0 ? 2 : 3);
      end
      checks++;
      if ({d, r, l} !== {32'hA000_0001 + i, 2'b00, i == 3}) begin
        errors++; $display("FAIL single_beat%0d got %h/%b/%b exp %h/00/%b", i, d, r, l, 32'hA000_0001 + i, i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_arready, a_rvalid, a_rlast} !== 3'b100) begin
      errors++; $display("FAIL single_done got %b exp 100", {a_arready, a_rvalid, a_rlast});
    end
    checks++;
    if (qa.size() != 4 || qa[0] != 8'h01 || qa[1] != 8'h02 || qa[2] != 8'h03 || qa[3] != 8'h04) begin
      errors++; $display("FAIL single_addrs got %p exp 01,02,03,04", qa);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d; logic [1:0] r; logic l, v; int w, n0;
    qa.delete(); rready = 1'b1;
    start_ar(8'h01);
    get_beat(1'b0, 10, d, r, l, v, w);
    checks++;
    if ({v, d} !== {1'b1, 32'hA000_0001}) begin errors++; $display("FAIL bp_beat0 got %b/%h exp 1/a0000001", v, d); end
    get_beat(1'b0, 10, d, r, l, v, w);
    rready = 1'b0;
    checks++;
    if ({v, d} !== {1'b1, 32'hA000_0002}) begin errors++; $display("FAIL bp_beat1 got %b/%h exp 1/a0000002", v, d); end
    n0 = qa.size();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if ({a_rvalid, a_rdata, a_rresp, a_rlast, a_sram_en} !== {1'b1, 32'hA000_0002, 2'b00, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_stall%0d got v=%b d=%h r=%b l=%b en=%b exp 1/a0000002/00/0/0",
                           s, a_rvalid, a_rdata, a_rresp, a_rlast, a_sram_en);
      end
    end
    checks++;
    if (qa.size() != n0) begin errors++; $display("FAIL bp_no_fetch got %0d exp %0d", qa.size(), n0); end
    rready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      get_beat(1'b0, 10, d, r, l, v, w);
      checks++;
      if ({v, d, r, l} !== {1'b1, 32'hA000_0001 + i, 2'b00, i == 3}) begin
        errors++; $display("FAIL bp_beat%0d got %b/%h/%b/%b exp 1/%h/00/%b", i, v, d, r, l, 32'hA000_0001 + i, i == 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [31:0] d; logic [1:0] r; logic l, v; int w;
    logic [7:0] ea [4];
    ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    qa.delete(); rready = 1'b1;
    start_ar(8'hFE);
    for (int i = 0; i < 4; i++) begin
      get_beat(1'b0, 10, d, r, l, v, w);
      checks++;
      if ({v, d, r, l} !== {1'b1, 32'hA000_0000 + ea[i], 2'b00, i == 3}) begin
        errors++; $display("FAIL wrap_beat%0d got %b/%h/%b/%b exp 1/%h/00/%b", i, v, d, r, l, 32'hA000_0000 + ea[i], i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (qa.size() != 4 || qa[0] != 8'hFE || qa[1] != 8'hFF || qa[2] != 8'h00 || qa[3] != 8'h01) begin
      errors++; $display("FAIL wrap_addrs got %p exp fe,ff,00,01", qa);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d; logic [1:0] r; logic l, v; int w;
    logic [31:0] ed; logic [1:0] er;
    qb.delete(); rready = 1'b1;
    start_ar(8'd198);
    for (int i = 0; i < 4; i++) begin
      get_beat(1'b1, 10, d, r, l, v, w);
      ed = (i < 2) ? 32'hA000_0000 + 198 + i : 32'h0;
      er = (i < 2) ? 2'b00 : 2'b10;
      checks++;
      if ({v, d, r, l} !== {1'b1, ed, er, i == 3}) begin
        errors++; $display("FAIL oor_beat%0d got %b/%h/%b/%b exp 1/%h/%b/%b", i, v, d, r, l, ed, er, i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (qb.size() != 2 || qb[0] != 8'd198 || qb[1] != 8'd199) begin
      errors++; $display("FAIL oor_addrs got %p exp c6,c7", qb);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic [1:0] r; logic l, v; int w;
    rready = 1'b1;
    araddr = 8'h20; arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a_arready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", k, a_arready); end
      @(negedge clk);
      checks++;
      if ({a_arready, a_sram_en, a_sram_addr} !== {1'b0, 1'b1, 8'h20 + 8'(k)}) begin
        errors++; $display("FAIL b2b_accept%0d got %b/%b/%h exp 0/1/%h", k, a_arready, a_sram_en, a_sram_addr, 8'h20 + 8'(k));
      end
      // Requester already presents the next address and holds it mid-burst
      if (k < 2) araddr = 8'h21 + 8'(k);
      else arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        get_beat(1'b0, 10, d, r, l, v, w);
        checks++;
        if ({v, d, l, a_arready} !== {1'b1, 32'hA000_0020 + k + i, i == 3, 1'b0}) begin
          errors++; $display("FAIL b2b_beat%0d_%0d got %b/%h/%b/ar=%b exp 1/%h/%b/0",
                             k, i, v, d, l, a_arready, 32'hA000_0020 + k + i, i == 3);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic [1:0] r; logic l, v; int w;
    rready = 1'b1;
    start_ar(8'h05);
    get_beat(1'b0, 10, d, r, l, v, w);
    rready = 1'b0;
    checks++;
    if ({v, d} !== {1'b1, 32'hA000_0005}) begin errors++; $display("FAIL rstmid_beat0 got %b/%h exp 1/a0000005", v, d); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rvalid, a_rlast, a_sram_en, a_arready} !== 4'b0001) begin
      errors++; $display("FAIL rstmid_async got %b exp 0001", {a_rvalid, a_rlast, a_sram_en, a_arready});
    end
    @(negedge clk);
    rst_n = 1'b1; rready = 1'b1;
    @(negedge clk);
    start_ar(8'h10);
    for (int i = 0; i < 4; i++) begin
      get_beat(1'b0, 10, d, r, l, v, w);
      checks++;
      if ({v, d, r, l} !== {1'b1, 32'hA000_0010 + i, 2'b00, i == 3}) begin
        errors++; $display("FAIL rstmid_beat%0d got %b/%h/%b/%b exp 1/%h/00/%b", i, v, d, r, l, 32'hA000_0010 + i, i == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (a_arready !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", a_arready); end
  endtask

  initial begin
    rst_n = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_backpressure();
    test_wrap();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

endmodule
